// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator arithmetic datapath.
package calc_pkg;
  localparam int W  = 8;
  localparam int RW = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;
endpackage

// File: rtl/signed_div8.sv
// Combinational signed 8-bit divider. The quotient truncates toward zero and
// is sign-extended to RW bits. A zero divisor raises div_by_zero.
module signed_div8
  import calc_pkg::*;
(
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  output logic signed [RW-1:0] q,
  output logic                 div_by_zero
);

  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W-1:0] q_mag;
  logic         q_neg;

  // Magnitudes fit in W unsigned bits, including |-128| = 128.
  assign a_mag       = a[W-1] ? W'(-a) : a;
  assign b_mag       = b[W-1] ? W'(-b) : b;
  assign q_neg       = a[W-1] ^ b[W-1];
  assign div_by_zero = (b == '0);

  // Restoring division on the magnitudes, one quotient bit per step, MSB first.
  always_comb begin
    logic [W:0] rem;
    q_mag = '0;
    rem   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      rem = {rem[W-1:0], a_mag[i]};
      if (rem >= {1'b0, b_mag}) begin
        rem      = rem - {1'b0, b_mag};
        q_mag[i] = 1'b1;
      end
    end
  end

  // The magnitude is widened before negation so -128/-1 yields +128.
  assign q = q_neg ? -$signed({{(RW-W){1'b0}}, q_mag})
                   :  $signed({{(RW-W){1'b0}}, q_mag});

endmodule

// File: rtl/op_decoder.sv
// Signed arithmetic unit: add/sub/mul/div of A and B selected by {S_1,S_0}.
// The full-width result is registered once; R is valid every cycle.
module op_decoder
  import calc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 S_1,
  input  logic                 S_0,
  input  logic signed [W-1:0]  A,
  input  logic signed [W-1:0]  B,
  output logic signed [RW-1:0] R
);

  op_e                op;
  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic signed [RW-1:0] prod;
  logic signed [RW-1:0] quot;
  logic                 div_by_zero;
  logic signed [RW-1:0] r_next;

  assign op    = op_e'({S_1, S_0});
  assign a_ext = {{(RW-W){A[W-1]}}, A};
  assign b_ext = {{(RW-W){B[W-1]}}, B};
  assign prod  = a_ext * b_ext;

  signed_div8 u_div (
    .a           (A),
    .b           (B),
    .q           (quot),
    .div_by_zero (div_by_zero)
  );

  // Opcode mux; a zero divisor yields a clean zero rather than a garbage quotient.
  always_comb begin
    r_next = '0;
    unique case (op)
      OP_ADD: r_next = a_ext + b_ext;
      OP_SUB: r_next = a_ext - b_ext;
      OP_MUL: r_next = prod;
      OP_DIV: r_next = div_by_zero ? '0 : quot;
      default: r_next = '0;
    endcase
  end

  // Result register; reset clears it immediately and drops any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) R <= '0;
    else        R <= r_next;
  end

endmodule

// File: tb/tb_op_decoder.sv
// Scoreboard bench for op_decoder: expectations are queued when inputs are
// driven and popped when the registered result is sampled.
module tb_op_decoder;
  import calc_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 S_1, S_0;
  logic signed [W-1:0]  A, B;
  logic signed [RW-1:0] R;

  int n_chk  = 0;
  int n_pass = 0;
  logic signed [RW-1:0] exp_q[$];

  op_decoder dut (
    .clk   (clk),
    .reset (reset),
    .S_1   (S_1),
    .S_0   (S_0),
    .A     (A),
    .B     (B),
    .R     (R)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0d (%h) want %0d (%h)", tag, $signed(obs), obs, $signed(want), want);
  endtask

  function automatic logic signed [RW-1:0] model(input int a, input int b, input logic [1:0] op);
    case (op)
      2'b00:   return 16'(a + b);
      2'b01:   return 16'(a - b);
      2'b10:   return 16'(a * b);
      default: return (b == 0) ? 16'sd0 : 16'(a / b);
    endcase
  endfunction

  task automatic pop_chk(input string tag);
    logic signed [RW-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, R, e);
    end
  endtask

  // Apply one operation between edges, queue its expectation, check after the edge.
  task automatic drive(input string tag, input int a, input int b, input logic [1:0] op);
    @(negedge clk);
    A = 8'(a); B = 8'(b); {S_1, S_0} = op;
    exp_q.push_back(model(a, b, op));
    @(posedge clk); #1;
    pop_chk(tag);
  endtask

  initial begin
    reset = 1'b0; A = '0; B = '0; S_1 = 1'b0; S_0 = 1'b0;
    #1 chk("reset_init", R, 16'd0);
    @(negedge clk); reset = 1'b1;

    drive("t1_add", 5, 3, 2'b00);
    drive("t1_mul", 5, 3, 2'b10);
    drive("t1_div", 5, 3, 2'b11);
    drive("t1_sub", 5, 3, 2'b01);

    drive("t2_add", -27, -24, 2'b00);
    drive("t2_sub", -27, -24, 2'b01);
    drive("t2_mul", -27, -24, 2'b10);
    drive("t2_div", -27, -24, 2'b11);

    drive("t3_addmin", -128, -128, 2'b00);
    drive("t3_mulmin", -128, -128, 2'b10);
    drive("t3_divmin", -128, -1,   2'b11);
    drive("t3_submax", 127,  -128, 2'b01);
    chk("t3_const_add", model(-128, -128, 2'b00), -16'sd256);
    chk("t3_const_div", model(-128, -1, 2'b11), 16'sd128);

    drive("t4_divtrunc",  -7, 2,  2'b11);
    drive("t4_divtrunc2", 7,  -2, 2'b11);
    drive("t4_div0",      7,  0,  2'b11);

    // Async reset between edges, held across an edge, then released.
    drive("t5_pre", 5, 3, 2'b00);
    @(negedge clk); #2 reset = 1'b0;
    #1 chk("t5_rst_async", R, 16'd0);
    @(posedge clk); #1 chk("t5_rst_hold", R, 16'd0);
    @(negedge clk);
    A = 8'sd5; B = 8'sd3; {S_1, S_0} = 2'b10; reset = 1'b1;
    exp_q.push_back(model(5, 3, 2'b10));
    @(posedge clk); #1 pop_chk("t5_release");

    for (int i = 0; i < 1000; i++) begin
      int a, b;
      logic [1:0] op;
      a  = int'($urandom_range(0, 255)) - 128;
      b  = int'($urandom_range(0, 255)) - 128;
      op = 2'($urandom_range(0, 3));
      drive("t6_rand", a, b, op);
      chk("t6_nox", {15'd0, $isunknown(R)}, 16'd0);
    end

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
